twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/twiddle_pkg.sv | 34 +++
 rtl/twiddle_rom.sv | 38 +++
 rtl/twiddle_gen.sv | 139 +++++++++++++
 tb/tb_twiddle_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor generator: FSM states, default sizes,
// Q1.(W-1) quantiser and the elaboration-time quarter-wave cosine table builder.
package twiddle_pkg;

  localparam int  N_MAX_DEFAULT = 1024;
  localparam int  W_DEFAULT     = 16;
  localparam real PI            = 3.14159265358979323846;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Round half away from zero, then clamp symmetric so +1.0 maps to 2^(w-1)-1.
  function automatic int quantise(real x, int w);
    real scaled;
    int  lim;
    int  v;
    lim    = (1 << (w - 1)) - 1;
    scaled = x * real'(1 << (w - 1));
    if (scaled >= 0.0) v = $rtoi(scaled + 0.5);
    else               v = $rtoi(scaled - 0.5);
    if (v > lim)       v = lim;
    else if (v < -lim) v = -lim;
    return v;
  endfunction

  // One entry C[i] = cos(2*pi*i/n_max) of the quarter-wave table, evaluated at elaboration.
  function automatic int cos_table_entry(int i, int n_max, int w);
    return quantise($cos(2.0 * PI * real'(i) / real'(n_max)), w);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table C[0..Q] with two registered read ports sharing one enable.
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int AW    = $clog2(N_MAX) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [W-1:0]  data_a,
  output logic [W-1:0]  data_b
);

  localparam int Q = N_MAX / 4;

  logic [W-1:0] table_q [0:Q];

  generate
    for (genvar gi = 0; gi <= Q; gi++) begin : g_entry
      assign table_q[gi] = W'(cos_table_entry(gi, N_MAX, W));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a <= '0;
      data_b <= '0;
    end else if (rd_en) begin
      data_a <= table_q[addr_a];
      data_b <= table_q[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 DIF twiddle sequencer: index counters feed a quarter-wave ROM, whose registered
// outputs are folded into the right quadrant and sign for FFT/IFFT, behind a valid/ready port.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   log2n,
  input  logic         inverse,
  output logic [W-1:0] tw_re,
  output logic [W-1:0] tw_im,
  output logic [3:0]   tw_stage,
  output logic         tw_valid,
  input  logic         tw_ready,
  output logic         tw_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int             LW        = $clog2(N_MAX);
  localparam int             AW        = LW - 1;
  localparam logic [3:0]     LOG2_NMAX = 4'(LW);
  localparam logic [AW-1:0]  Q_ADDR    = AW'(N_MAX / 4);
  localparam logic [LW-2:0]  ONE_K     = 1;

  state_t        state_reg, state_next;
  logic [3:0]    log2n_reg, sh_reg, s_reg;
  logic [LW-2:0] k_reg, half_mask_reg;
  logic          inv_reg;
  logic          v2_reg, last2_reg, quad2_reg, inv2_reg;
  logic [3:0]    stage2_reg;
  logic          done_reg, err_reg;

  logic          adv, log2n_ok, start_ok, idx_last, last_hs;
  logic [LW-2:0] e_idx, e_rom;
  logic          quad;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  rom_a, rom_b, cos_v, sin_v;

  // The pipeline only moves when the output slot is empty or being consumed.
  assign adv      = !v2_reg || tw_ready;
  assign log2n_ok = (log2n >= 4'd3) && (log2n <= LOG2_NMAX);
  assign start_ok = start && (state_reg == IDLE) && !done_reg && log2n_ok;
  assign idx_last = (s_reg == log2n_reg - 4'd1) && (k_reg == half_mask_reg);
  assign last_hs  = v2_reg && tw_ready && last2_reg;

  // e = (k mod (n >> (s+1))) << s, then rescaled into the N_MAX-point ROM domain.
  assign e_idx  = (k_reg & (half_mask_reg >> s_reg)) << s_reg;
  assign e_rom  = e_idx << sh_reg;
  assign quad   = e_rom[LW-2];
  assign addr_a = {1'b0, e_rom[LW-3:0]};
  assign addr_b = Q_ADDR - addr_a;

  twiddle_rom #(.N_MAX(N_MAX), .W(W), .AW(AW)) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (adv),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (rom_a),
    .data_b (rom_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (adv && idx_last) state_next = DRAIN;
      DRAIN:   if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log2n_reg     <= '0;
      sh_reg        <= '0;
      s_reg         <= '0;
      k_reg         <= '0;
      half_mask_reg <= '0;
      inv_reg       <= 1'b0;
      v2_reg        <= 1'b0;
      last2_reg     <= 1'b0;
      quad2_reg     <= 1'b0;
      inv2_reg      <= 1'b0;
      stage2_reg    <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= (state_reg == DRAIN) && last_hs;
      err_reg  <= start && (state_reg == IDLE) && !done_reg && !log2n_ok;
      if (start_ok) begin
        log2n_reg     <= log2n;
        inv_reg       <= inverse;
        sh_reg        <= LOG2_NMAX - log2n;
        half_mask_reg <= (ONE_K << (log2n - 4'd1)) - ONE_K;
        s_reg         <= '0;
        k_reg         <= '0;
      end else if ((state_reg == RUN) && adv) begin
        if (k_reg == half_mask_reg) begin
          k_reg <= '0;
          s_reg <= s_reg + 4'd1;
        end else begin
          k_reg <= k_reg + ONE_K;
        end
      end
      if (adv) begin
        v2_reg     <= (state_reg == RUN);
        last2_reg  <= (state_reg == RUN) && idx_last;
        quad2_reg  <= quad;
        inv2_reg   <= inv_reg;
        stage2_reg <= s_reg;
      end
    end
  end

  // Quadrant 1 swaps the ports and negates cosine; FFT mode negates sine.
  assign cos_v    = quad2_reg ? -rom_b : rom_a;
  assign sin_v    = quad2_reg ? rom_a : rom_b;
  assign tw_re    = cos_v;
  assign tw_im    = inv2_reg ? sin_v : -sin_v;
  assign tw_stage = stage2_reg;
  assign tw_valid = v2_reg;
  assign tw_last  = last2_reg;
  assign busy     = (state_reg != IDLE) || done_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: stimulus pushes expected twiddles, a negedge monitor
// pops and compares on every handshake and checks held outputs during stalls.
module tb_twiddle_gen;

  localparam real PI_TB = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  log2n;
  logic        inverse;
  logic [15:0] tw_re, tw_im;
  logic [3:0]  tw_stage;
  logic        tw_valid, tw_ready, tw_last, busy, done, err;

  twiddle_gen #(.N_MAX(1024), .W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .log2n    (log2n),
    .inverse  (inverse),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_stage (tw_stage),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_last  (tw_last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int stage;
    bit last;
    int tol;
  } exp_t;

  exp_t sb [$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   out_count   = 0;
  bit   expect_done = 1'b0;
  bit   done_seen   = 1'b0;
  bit   rand_mode   = 1'b0;

  // Hand-computed n=8 FFT sequence (stage 0: e=0..3, stage 1: e=0,2,0,2, stage 2: e=0).
  int re8 [12] = '{32767, 23170, 0, -23170, 32767, 0, 32767, 0, 32767, 32767, 32767, 32767};
  int im8 [12] = '{0, -23170, -32767, -23170, 0, -32767, 0, -32767, 0, 0, 0, 0};

  task automatic check(string name, longint act, longint exp, longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int qnt(real x);
    real v;
    int  r;
    v = x * 32768.0;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  task automatic push_directed8(bit inv);
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.re    = re8[i];
      e.im    = inv ? -im8[i] : im8[i];
      e.stage = i / 4;
      e.last  = (i == 11);
      e.tol   = 0;
      sb.push_back(e);
    end
  endtask

  task automatic push_model(int l2n, bit inv);
    exp_t e;
    int   n, ex;
    real  ang;
    n = 1 << l2n;
    for (int s = 0; s < l2n; s++) begin
      for (int k = 0; k < n / 2; k++) begin
        ex      = (k % (n >> (s + 1))) << s;
        ang     = 2.0 * PI_TB * real'(ex) / real'(n);
        e.re    = qnt($cos(ang));
        e.im    = inv ? qnt($sin(ang)) : qnt(-$sin(ang));
        e.stage = s;
        e.last  = (s == l2n - 1) && (k == n / 2 - 1);
        e.tol   = 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic issue(int l2n, bit inv);
    @(posedge clk); #1;
    start     = 1'b1;
    log2n     = 4'(l2n);
    inverse   = inv;
    out_count = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, int exp_count, int l2n);
    int c;
    c = 0;
    while (!done_seen && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_timeout", done_seen, 1, 0);
    check("output_count", out_count, exp_count, 0);
    check("scoreboard_empty", sb.size(), 0, 0);
    $display("seq log2n=%0d outputs=%0d expected=%0d cycles=%0d", l2n, out_count, exp_count, c);
    done_seen = 1'b0;
  endtask

  // tw_ready driver: always 1 unless random back-pressure is enabled.
  initial begin
    tw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tw_ready = rand_mode ? ($urandom_range(0, 9) < 6) : 1'b1;
    end
  end

  // Monitor: compares handshaked outputs, held values under stall, and the done pulse.
  initial begin : monitor
    exp_t   e;
    bit     stall_prev;
    longint snap, now;
    stall_prev = 1'b0;
    snap       = 0;
    forever begin
      @(negedge clk);
      now = longint'({tw_valid, tw_last, tw_stage, tw_re, tw_im});
      if (!rst_n) begin
        stall_prev  = 1'b0;
        expect_done = 1'b0;
      end else begin
        check("done_pulse", done, expect_done, 0);
        if (expect_done) done_seen = 1'b1;
        expect_done = 1'b0;
        if (stall_prev) check("stall_hold", now, snap, 0);
        if (tw_valid && tw_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0, 0);
          end else begin
            e = sb.pop_front();
            check("tw_re", int'($signed(tw_re)), e.re, e.tol);
            check("tw_im", int'($signed(tw_im)), e.im, e.tol);
            check("tw_stage", tw_stage, e.stage, 0);
            check("tw_last", tw_last, e.last, 0);
            out_count++;
            if (e.last) expect_done = 1'b1;
          end
        end
        stall_prev = tw_valid && !tw_ready;
        snap       = now;
      end
    end
  end

  initial begin : stimulus
    int c;
    rst_n   = 1'b1;
    start   = 1'b0;
    log2n   = 4'd0;
    inverse = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tw_valid, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_done_err", {done, err, tw_last}, 0, 0);
    check("rst_re_im", {tw_re, tw_im}, 0, 0);
    check("rst_stage", tw_stage, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // n=8 FFT with first-output latency check.
    push_directed8(1'b0);
    issue(3, 1'b0);
    check("latency_c1_valid", tw_valid, 0, 0);
    check("busy_after_start", busy, 1, 0);
    @(posedge clk); #1;
    check("latency_c2_valid", tw_valid, 1, 0);
    wait_done(100, 12, 3);

    // n=8 IFFT with a start pulsed mid-run that must be ignored.
    push_directed8(1'b1);
    issue(3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    log2n = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_start_in_run", err, 0, 0);
    wait_done(100, 12, 3);
    repeat (4) @(posedge clk);
    check("idle_after_ignored_start", busy, 0, 0);

    // Start coinciding with the done cycle must be ignored.
    push_directed8(1'b0);
    issue(3, 1'b0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(tw_valid && tw_ready && tw_last) && c < 100);
    check("last_seen_timeout", c < 100, 1, 0);
    @(posedge clk); #1;
    start = 1'b1;
    check("done_cycle_done", done, 1, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_cycle_err", err, 0, 0);
    check("done_cycle_busy", busy, 0, 0);
    wait_done(100, 12, 3);
    repeat (6) @(posedge clk);
    #1;
    check("count_after_done_start", out_count, 12, 0);
    check("valid_after_done_start", tw_valid, 0, 0);

    // Out-of-range sizes raise a one-cycle err and never start.
    for (int t = 0; t < 2; t++) begin
      issue(t == 0 ? 2 : 11, 1'b0);
      check("err_pulse", err, 1, 0);
      check("err_busy", busy, 0, 0);
      @(posedge clk); #1;
      check("err_one_cycle", err, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("err_no_valid", tw_valid, 0, 0);
      check("err_no_busy", busy, 0, 0);
    end

    // Asynchronous reset after 40 outputs of an n=64 run, then a clean full run.
    push_model(6, 1'b0);
    issue(6, 1'b0);
    c = 0;
    while (out_count < 40 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("reach_output_40", out_count >= 40, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", tw_valid, 0, 0);
    check("midrst_busy", busy, 0, 0);
    check("midrst_outputs", {tw_re, tw_im, tw_stage, tw_last}, 0, 0);
    sb.delete();
    done_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", busy, 0, 0);
    push_model(6, 1'b0);
    issue(6, 1'b0);
    wait_done(1000, 192, 6);

    // n=1024 under random back-pressure against the real-valued model.
    rand_mode = 1'b1;
    push_model(10, 1'b0);
    issue(10, 1'b0);
    wait_done(40000, 5120, 10);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
